// File: rtl/piece_spawn_ctrl_if.sv
// Signal bundle between piece_spawn_ctrl, the game FSM, the spawn generator and the board read port.
// master = the controller, slave = its environment.
`ifndef NULL_PIECE
`define I_PIECE    3'd0
`define O_PIECE    3'd1
`define T_PIECE    3'd2
`define S_PIECE    3'd3
`define Z_PIECE    3'd4
`define J_PIECE    3'd5
`define L_PIECE    3'd6
`define NULL_PIECE 3'd7
`endif

interface piece_spawn_ctrl_if #(
  parameter int POS_W = 5
);
  logic                   spawn_req;
  logic                   hold_req;
  logic                   gen_enable;
  logic [2:0]             gen_hold_type;
  logic                   gen_real;
  logic [POS_W-1:0]       gen_pos_i;
  logic [POS_W-1:0]       gen_pos_j;
  logic [2:0]             gen_piece_type;
  logic                   gen_done;
  logic [POS_W-1:0]       brd_rd_i;
  logic [POS_W-1:0]       brd_rd_j;
  logic                   brd_rd_occ;
  logic [4*2*POS_W-1:0]   piece_cells;
  logic [2:0]             piece_type;
  logic                   piece_valid;
  logic                   busy;
  logic [2:0]             hold_type;
  logic                   hold_used;
  logic                   game_over;

  modport master (
    input  spawn_req, hold_req,
    input  gen_pos_i, gen_pos_j, gen_piece_type, gen_done,
    input  brd_rd_occ,
    output gen_enable, gen_hold_type, gen_real,
    output brd_rd_i, brd_rd_j,
    output piece_cells, piece_type, piece_valid, busy,
    output hold_type, hold_used, game_over
  );

  modport slave (
    output spawn_req, hold_req,
    output gen_pos_i, gen_pos_j, gen_piece_type, gen_done,
    output brd_rd_occ,
    input  gen_enable, gen_hold_type, gen_real,
    input  brd_rd_i, brd_rd_j,
    input  piece_cells, piece_type, piece_valid, busy,
    input  hold_type, hold_used, game_over
  );
endinterface

// File: rtl/piece_spawn_ctrl.sv
// Spawn sequencer: runs the generator for four cells, checks them on the board, then presents the piece or game over.
// 10 cycles request-to-valid; requests during GEN/CHECK are dropped. Hold slot built only with SPAWN_HOLD_EN.
`ifndef NULL_PIECE
`define I_PIECE    3'd0
`define O_PIECE    3'd1
`define T_PIECE    3'd2
`define S_PIECE    3'd3
`define Z_PIECE    3'd4
`define J_PIECE    3'd5
`define L_PIECE    3'd6
`define NULL_PIECE 3'd7
`endif

module piece_spawn_ctrl #(
  parameter int POS_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  piece_spawn_ctrl_if.master   bus
);
  localparam int CW = 2 * POS_W;

  typedef enum logic [2:0] {IDLE, GEN, CHECK, ACTIVE, OVER} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cell_q [4];
  logic [CW-1:0]   cell_d [4];
  logic [2:0]      piece_type_q, piece_type_d;
  logic            piece_valid_q, piece_valid_d;
  logic            game_over_q, game_over_d;
  logic            go_hold;
  logic [CW-1:0]   cur_cell;

  assign cur_cell = cell_q[idx_q];

`ifdef SPAWN_HOLD_EN
  logic [2:0] hold_type_q, hold_type_d;
  logic [2:0] gen_hold_type_q, gen_hold_type_d;
  logic       hold_used_q, hold_used_d;
  logic       gen_real_q, gen_real_d;

  assign go_hold = bus.hold_req && !bus.spawn_req && !hold_used_q;

  always_comb begin
    hold_type_d     = hold_type_q;
    gen_hold_type_d = gen_hold_type_q;
    hold_used_d     = hold_used_q;
    gen_real_d      = gen_real_q;
    if ((state_q == IDLE || state_q == ACTIVE) && bus.spawn_req) begin
      gen_hold_type_d = `NULL_PIECE;
      gen_real_d      = 1'b1;
      hold_used_d     = 1'b0;
    end else if (state_q == ACTIVE && go_hold) begin
      // An occupied slot replays its piece without advancing the queue.
      gen_hold_type_d = hold_type_q;
      gen_real_d      = (hold_type_q == `NULL_PIECE);
      hold_type_d     = piece_type_q;
      hold_used_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_type_q     <= `NULL_PIECE;
      gen_hold_type_q <= `NULL_PIECE;
      hold_used_q     <= 1'b0;
      gen_real_q      <= 1'b0;
    end else begin
      hold_type_q     <= hold_type_d;
      gen_hold_type_q <= gen_hold_type_d;
      hold_used_q     <= hold_used_d;
      gen_real_q      <= gen_real_d;
    end
  end

  assign bus.hold_type     = hold_type_q;
  assign bus.gen_hold_type = gen_hold_type_q;
  assign bus.hold_used     = hold_used_q;
  assign bus.gen_real      = gen_real_q;
`else
  logic unused_hold_req;
  assign unused_hold_req   = bus.hold_req;
  assign go_hold           = 1'b0;
  assign bus.hold_type     = `NULL_PIECE;
  assign bus.gen_hold_type = `NULL_PIECE;
  assign bus.hold_used     = 1'b0;
  assign bus.gen_real      = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cell_d        = cell_q;
    piece_type_d  = piece_type_q;
    piece_valid_d = piece_valid_q;
    game_over_d   = game_over_q;
    case (state_q)
      IDLE: begin
        if (bus.spawn_req) state_d = GEN;
      end
      ACTIVE: begin
        if (bus.spawn_req || go_hold) begin
          state_d       = GEN;
          piece_valid_d = 1'b0;
        end
      end
      GEN: begin
        if (bus.gen_done) begin
          piece_type_d = bus.gen_piece_type;
          idx_d        = 2'd0;
          state_d      = CHECK;
        end else begin
          cell_d[idx_q] = {bus.gen_pos_i, bus.gen_pos_j};
          idx_d         = idx_q + 2'd1;
        end
      end
      CHECK: begin
        // First occupied cell ends the game; later cells are not read.
        if (bus.brd_rd_occ) begin
          state_d       = OVER;
          game_over_d   = 1'b1;
          piece_valid_d = 1'b0;
        end else if (idx_q == 2'd3) begin
          state_d       = ACTIVE;
          piece_valid_d = 1'b1;
          idx_d         = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      piece_type_q  <= 3'd0;
      piece_valid_q <= 1'b0;
      game_over_q   <= 1'b0;
      for (int n = 0; n < 4; n++) cell_q[n] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      piece_type_q  <= piece_type_d;
      piece_valid_q <= piece_valid_d;
      game_over_q   <= game_over_d;
      for (int n = 0; n < 4; n++) cell_q[n] <= cell_d[n];
    end
  end

  assign bus.gen_enable  = (state_q == GEN);
  assign bus.busy        = (state_q == GEN) || (state_q == CHECK);
  assign bus.brd_rd_i    = cur_cell[CW-1:POS_W];
  assign bus.brd_rd_j    = cur_cell[POS_W-1:0];
  assign bus.piece_cells = {cell_q[3], cell_q[2], cell_q[1], cell_q[0]};
  assign bus.piece_type  = piece_type_q;
  assign bus.piece_valid = piece_valid_q;
  assign bus.game_over   = game_over_q;
endmodule

// File: tb/tb_piece_spawn_ctrl.sv
// Bench for piece_spawn_ctrl: generator/board models plus a per-request reference model of the spawn/hold rules.
`ifndef NULL_PIECE
`define I_PIECE    3'd0
`define O_PIECE    3'd1
`define T_PIECE    3'd2
`define S_PIECE    3'd3
`define Z_PIECE    3'd4
`define J_PIECE    3'd5
`define L_PIECE    3'd6
`define NULL_PIECE 3'd7
`endif

module tb_piece_spawn_ctrl;
`ifdef SPAWN_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  piece_spawn_ctrl_if #(.POS_W(5)) bus ();
  piece_spawn_ctrl #(.POS_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Generator model: emits g_i/g_j cells 0..3 then done; type from queue or forced hold type.
  logic [2:0] gen_seq [256];
  logic [7:0] gen_ptr = 8'd0;
  logic [2:0] gcnt = 3'd0;
  logic [4:0] g_i [4];
  logic [4:0] g_j [4];
  logic       occ [32][32];

  always @(posedge clk) begin
    gcnt <= bus.gen_enable ? gcnt + 3'd1 : 3'd0;
    if (bus.gen_done && bus.gen_real) gen_ptr <= gen_ptr + 8'd1;
  end
  assign bus.gen_done       = bus.gen_enable && (gcnt == 3'd4);
  assign bus.gen_pos_i      = g_i[gcnt[1:0]];
  assign bus.gen_pos_j      = g_j[gcnt[1:0]];
  assign bus.gen_piece_type = (bus.gen_hold_type != `NULL_PIECE) ? bus.gen_hold_type : gen_seq[gen_ptr];
  assign bus.brd_rd_occ     = occ[bus.brd_rd_i][bus.brd_rd_j];

  // Reference model state
  bit         m_idle, m_active, m_over;
  logic [2:0] m_type, m_hold;
  bit         m_hold_used;
  logic [7:0] m_ptr;
  logic [39:0] m_cells;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_active = 0; m_over = 0;
    m_type = 3'd0; m_hold = `NULL_PIECE; m_hold_used = 0; m_cells = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"},  bus.busy, 1'b0);
    chk({tag, ".gen_en"}, bus.gen_enable, 1'b0);
    chk({tag, ".valid"}, bus.piece_valid, 1'b0);
    chk({tag, ".over"},  bus.game_over, 1'b0);
    chk({tag, ".type"},  bus.piece_type, 3'd0);
    chk({tag, ".cells"}, bus.piece_cells, 40'd0);
    chk({tag, ".brd"},   {bus.brd_rd_i, bus.brd_rd_j}, 10'd0);
    chk({tag, ".hold"},  bus.hold_type, `NULL_PIECE);
    chk({tag, ".ghold"}, bus.gen_hold_type, `NULL_PIECE);
    chk({tag, ".hused"}, bus.hold_used, 1'b0);
    chk({tag, ".greal"}, bus.gen_real, HOLD_EN ? 1'b0 : 1'b1);
  endtask

  // One request in the current cycle; spur_c>0 pulses another request at that busy cycle.
  task automatic run_req(input bit sp, input bit hd, input int spur_c, input bit spur_hold);
    bit accept, hold_mode, exp_real;
    logic [2:0] exp_ght, exp_type;
    logic [39:0] exp_cells;
    int nhit, last_busy;
    accept = 0; hold_mode = 0;
    if (!m_over) begin
      if (m_idle) accept = sp;
      else if (m_active) begin
        if (sp) accept = 1;
        else if (hd && HOLD_EN && !m_hold_used) begin accept = 1; hold_mode = 1; end
      end
    end
    bus.spawn_req = sp;
    bus.hold_req  = hd;
    tick();
    bus.spawn_req = 0;
    bus.hold_req  = 0;
    if (!accept) begin
      chk("ign.busy",  bus.busy, 1'b0);
      chk("ign.valid", bus.piece_valid, m_active);
      chk("ign.over",  bus.game_over, m_over);
      chk("ign.type",  bus.piece_type, m_type);
      chk("ign.cells", bus.piece_cells, m_cells);
      chk("ign.hold",  bus.hold_type, m_hold);
      chk("ign.hused", bus.hold_used, m_hold_used);
      return;
    end
    if (hold_mode) begin
      exp_ght  = m_hold;
      exp_real = (m_hold == `NULL_PIECE);
      exp_type = exp_real ? gen_seq[m_ptr] : m_hold;
      m_hold = m_type;
      m_hold_used = 1;
    end else begin
      exp_ght = `NULL_PIECE;
      exp_real = 1;
      exp_type = gen_seq[m_ptr];
      m_hold_used = 0;
    end
    if (exp_real) m_ptr++;
    exp_cells = {g_i[3], g_j[3], g_i[2], g_j[2], g_i[1], g_j[1], g_i[0], g_j[0]};
    nhit = 4;
    for (int n = 3; n >= 0; n--) if (occ[g_i[n]][g_j[n]]) nhit = n;
    last_busy = (nhit < 4) ? 6 + nhit : 9;
    for (int c = 1; c <= last_busy + 1; c++) begin
      chk($sformatf("c%0d.busy", c),  bus.busy, (c <= last_busy));
      chk($sformatf("c%0d.gen_en", c), bus.gen_enable, (c <= 5));
      chk($sformatf("c%0d.valid", c), bus.piece_valid, (nhit == 4 && c >= 10));
      chk($sformatf("c%0d.over", c),  bus.game_over, (nhit < 4 && c >= 7 + nhit));
      if (c == 1) begin
        chk("entry.greal", bus.gen_real, exp_real);
        chk("entry.ghold", bus.gen_hold_type, exp_ght);
        chk("entry.hold",  bus.hold_type, m_hold);
        chk("entry.hused", bus.hold_used, m_hold_used);
      end
      if (c <= last_busy) begin
        bus.spawn_req = (c == spur_c);
        bus.hold_req  = (c == spur_c) && spur_hold;
        tick();
      end
    end
    bus.spawn_req = 0;
    bus.hold_req  = 0;
    chk("done.type",  bus.piece_type, exp_type);
    chk("done.cells", bus.piece_cells, exp_cells);
    chk("done.hold",  bus.hold_type, m_hold);
    chk("done.hused", bus.hold_used, m_hold_used);
    m_idle = 0; m_type = exp_type; m_cells = exp_cells;
    m_active = (nhit == 4);
    m_over = (nhit < 4);
  endtask

  task automatic set_cells(input int c0i, c0j, c1i, c1j, c2i, c2j, c3i, c3j);
    g_i[0] = 5'(c0i); g_j[0] = 5'(c0j); g_i[1] = 5'(c1i); g_j[1] = 5'(c1j);
    g_i[2] = 5'(c2i); g_j[2] = 5'(c2j); g_i[3] = 5'(c3i); g_j[3] = 5'(c3j);
  endtask

  initial begin
    int r;
    bus.spawn_req = 0;
    bus.hold_req = 0;
    for (int a = 0; a < 32; a++) for (int b = 0; b < 32; b++) occ[a][b] = 1'b0;
    for (int n = 0; n < 256; n++) gen_seq[n] = 3'($urandom_range(0, 6));
    gen_seq[0] = `T_PIECE;
    set_cells(0, 4, 1, 3, 1, 4, 1, 5);
    m_ptr = 8'd0;
    model_reset();
    tick(); tick();
    reset = 0;
    tick();
    chk_reset_vals("rst");

    // IDLE ignores hold, then the directed T spawn
    run_req(0, 1, 0, 0);
    run_req(1, 0, 0, 0);
    // hold twice: second one ignored since hold already used
    set_cells(0, 3, 0, 4, 0, 5, 0, 6);
    run_req(0, 1, 0, 0);
    run_req(0, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int n = 0; n < 4; n++) begin
        g_i[n] = 5'($urandom_range(0, 31));
        g_j[n] = 5'($urandom_range(0, 31));
      end
      r = $urandom_range(0, 9);
      run_req(r <= 4 || r == 8, r >= 5 && r <= 8, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
    end

    // collision on the second cell of an I piece
    occ[1][4] = 1'b1;
    gen_seq[m_ptr] = `I_PIECE;
    set_cells(1, 3, 1, 4, 1, 5, 1, 6);
    run_req(1, 0, 0, 0);
    chk("over.type", bus.piece_type, `I_PIECE);
    run_req(1, 0, 0, 0);
    run_req(0, 1, 0, 0);
    occ[1][4] = 1'b0;

    // reset during GEN, then a clean spawn from cell 0
    set_cells(2, 2, 2, 3, 3, 2, 3, 3);
    reset = 1; tick(); reset = 0; tick();
    model_reset();
    bus.spawn_req = 1;
    tick();
    bus.spawn_req = 0;
    tick(); tick();
    #2 reset = 1;
    #1 chk_reset_vals("midgen");
    reset = 0;
    tick();
    model_reset();
    run_req(1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
